pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the single-cycle CPU. Drives the PC register's load enable and next value.
//  Selects the next PC by priority: exception, eret, jr, j/jal, branch, then sequential.
//  Holds the PC while the multi-cycle mult/div unit (MDU) is busy, and freezes it on break/halt.
// PARAMETERS
//  ADDR_W      32            PC width
//  RESET_ADDR  32'h00400000  PC after reset; must equal the PC register's default address
//  EXC_VECTOR  32'h00400004  single exception entry point
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  pc           in   ADDR_W  current PC from the PC register
//  br_taken     in   1       conditional branch resolved taken this cycle
//  br_target    in   ADDR_W  branch target (pc+4+offset<<2, computed upstream)
//  jmp          in   1       j/jal this cycle
//  jmp_target   in   ADDR_W  {pc[31:28],idx,2'b00}
//  jr           in   1       jr/jalr this cycle
//  jr_target    in   ADDR_W  rs value
//  exc_req      in   1       syscall/break/teq trap this cycle
//  eret         in   1       eret this cycle
//  epc_in       in   ADDR_W  CP0 EPC value
//  halt         in   1       stop fetch permanently (until rst)
//  mdu_start    in   1       multi-cycle mult/div issued this cycle
//  mdu_done     in   1       MDU result ready (1-cycle pulse)
//  pc_ena       out  1       load enable to the PC register
//  pc_next      out  ADDR_W  next PC to the PC register
//  exc_taken    out  1       exception redirect occurs this cycle (1-cycle pulse)
//  epc_out      out  ADDR_W  PC to write into EPC when exc_taken=1
//  stalled      out  1       state is WAIT_MDU
//  stall_cnt    out  32      total cycles spent in WAIT_MDU since reset; saturates at 32'hFFFFFFFF
//  misalign     out  1       see CONFIGURATION
// BEHAVIOUR
//  Timing
//  - pc_ena, pc_next, exc_taken and epc_out are combinational from the current state and inputs (zero latency).
//  - State, exc_pend and stall_cnt are registered on posedge clk.
//  Reset (rst=1 at posedge)
//  - state=RUN, exc_pend=0, stall_cnt=0.
//  - While rst=1: pc_ena=0, pc_next=RESET_ADDR, exc_taken=0, epc_out=0, misalign=0.
//  State RUN
//  - pc_ena=1. pc_next is chosen by priority:
//      exc_req -> EXC_VECTOR (exc_taken=1, epc_out=pc)
//      eret    -> epc_in
//      jr      -> jr_target
//      jmp     -> jmp_target
//      br_taken-> br_target
//      else    -> pc+4 (wraps modulo 2^ADDR_W; FFFFFFFC -> 00000000)
//  - mdu_start=1: pc_ena=0 this cycle; next state WAIT_MDU.
//    If mdu_start and a redirect input are both high, mdu_start wins and the redirect is ignored.
//  - halt=1: pc_ena=0; next state HALT. halt has priority over every other input.
//  State WAIT_MDU
//  - pc_ena=0; stall_cnt increments each cycle.
//  - exc_req arriving here sets exc_pend; it is not applied immediately.
//  - On mdu_done: pc_ena=1 and state returns to RUN.
//    pc_next = EXC_VECTOR if exc_pend or exc_req (exc_taken=1, epc_out=pc+4), else pc+4.
//    exc_pend clears.
//  - mdu_done in the same cycle as mdu_start is ignored; the WAIT_MDU minimum is 1 cycle.
//  - halt in WAIT_MDU moves to HALT and discards exc_pend.
//  State HALT
//  - pc_ena=0; only rst leaves this state.
//  Reset mid-operation
//  - rst in any state returns to RUN and clears the pending exception and the counter.
//  State encoding
//  - RUN=2'd0, WAIT_MDU=2'd1, HALT=2'd2. 2'd3 is illegal and recovers to RUN on the next clock.
// CONFIGURATION
//  - Macro PC_SEQ_ALIGN_CHK_EN defined:
//    if the selected redirect target has [1:0]!=0, pc_next=EXC_VECTOR, misalign=1, exc_taken=1, epc_out=pc.
//  - Macro undefined: targets pass through unchanged; misalign is tied to 0.
// STRUCTURE
//  - Shared defines header holds: state encodings, RESET_ADDR/EXC_VECTOR defaults, Enable/RstEnable levels,
//    and the InstAddrBus width.
//  - Sub-module pc_next_mux: purely combinational priority select and pc+4 adder. The FSM, exc_pend and
//    stall counter stay in pc_sequencer.
// TESTING
//  - Reset: rst=1 for 2 cycles -> pc_ena=0, pc_next=00400000. After release with pc=00400000 -> pc_next=00400004, pc_ena=1.
//  - Priority: pc=00400010 with exc_req, jr(00400100) and br(00400020) all high -> pc_next=00400004,
//    exc_taken=1, epc_out=00400010.
//  - MDU stall: mdu_start at pc=00400040, mdu_done 5 cycles later -> pc_ena=0 for 5 cycles,
//    stall_cnt=5, then pc_next=00400044.
//  - Pending exception: exc_req during WAIT_MDU, then mdu_done -> pc_next=00400004, epc_out=pc+4, exc_pend cleared.
//  - Wrap and halt: pc=FFFFFFFC -> pc_next=00000000. Then halt=1 -> pc_ena stays 0 for 20 cycles;
//    rst returns state to RUN.
//  - Macro defined: jr_target=00400102 -> misalign=1, pc_next=00400004.
//    Macro undefined: same stimulus -> pc_next=00400102, misalign=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer.
// Holds state encodings, default reset/exception addresses, enable/reset
// levels, the instruction address bus width and small helper functions.
// Optional alignment checking is controlled by macro PC_SEQ_ALIGN_CHK_EN
// (used in pc_next_mux).
package pc_sequencer_pkg;

    // Instruction address bus width
    localparam int unsigned INST_ADDR_BUS = 32;

    // Sequencer FSM encoding; 2'd3 is unused and recovers to RUN
    localparam int unsigned STATE_W     = 2;
    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_WAIT_MDU = 2'd1;
    localparam logic [1:0]  ST_HALT     = 2'd2;

    // Default addresses; RESET_ADDR must match the PC register's default
    localparam logic [31:0] RESET_ADDR_DFLT = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0040_0004;

    // Control levels
    localparam logic ENABLE     = 1'b1;
    localparam logic DISABLE    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    // Stall cycle counter
    localparam int unsigned            STALL_CNT_W   = 32;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    // True when a word address has non-zero byte offset bits
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    // Saturating increment for the stall counter
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == STALL_CNT_MAX) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// pc_next_mux: combinational priority select of the next PC in RUN state,
// plus the sequential pc+4 adder.
// Priority: exc_req > eret > jr > jmp > br_taken > pc+4.
// Macro PC_SEQ_ALIGN_CHK_EN: a misaligned redirect target is replaced by the
// exception vector and flagged on misalign_c; otherwise misalign_c is 0.
// Ports:
//   pc, targets, redirect requests  in   current PC and candidate targets
//   pc_plus4_c                      out  pc + 4 (wraps)
//   sel_pc_c                        out  selected next PC
//   exc_sel_c                       out  exception vector selected
//   misalign_c                      out  redirect target misaligned (macro only)
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = INST_ADDR_BUS,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DFLT)
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc_in,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_plus4_c,
    output logic [ADDR_W-1:0] sel_pc_c,
    output logic              exc_sel_c,
    output logic              misalign_c
);

    logic [ADDR_W-1:0] tgt_c;

    // Redirect target by priority, falling back to sequential fetch
    always_comb begin
        pc_plus4_c = pc + ADDR_W'(4);
        tgt_c      = pc_plus4_c;
        if (eret) begin
            tgt_c = epc_in;
        end else if (jr) begin
            tgt_c = jr_target;
        end else if (jmp) begin
            tgt_c = jmp_target;
        end else if (br_taken) begin
            tgt_c = br_target;
        end
    end

    // Exception overrides any redirect; optional alignment trap
    always_comb begin
        sel_pc_c   = tgt_c;
        exc_sel_c  = DISABLE;
        misalign_c = DISABLE;
        if (exc_req) begin
            sel_pc_c  = EXC_VECTOR;
            exc_sel_c = ENABLE;
        end
`ifdef PC_SEQ_ALIGN_CHK_EN
        else if ((eret || jr || jmp || br_taken) && addr_misaligned(tgt_c[1:0])) begin
            sel_pc_c   = EXC_VECTOR;
            exc_sel_c  = ENABLE;
            misalign_c = ENABLE;
        end
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle CPU.
// Drives the PC register load enable and next value, holds the PC while the
// multi-cycle mult/div unit is busy, freezes it on halt, and defers traps
// raised during an MDU stall until the MDU completes.
// Optional macro PC_SEQ_ALIGN_CHK_EN enables misaligned-target trapping.
// Ports:
//   clk, rst              in   clock, synchronous active-high reset
//   pc                    in   current PC
//   br_taken/br_target    in   taken branch and target
//   jmp/jmp_target        in   j/jal and target
//   jr/jr_target          in   jr/jalr and target
//   exc_req               in   trap request
//   eret/epc_in           in   exception return and EPC value
//   halt                  in   stop fetch until reset
//   mdu_start/mdu_done    in   MDU issue and completion pulse
//   pc_ena/pc_next        out  PC load enable and next value (combinational)
//   exc_taken/epc_out     out  exception redirect pulse and EPC to save
//   stalled               out  waiting on the MDU
//   stall_cnt             out  saturating count of MDU stall cycles
//   misalign              out  misaligned redirect trapped (macro only)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = INST_ADDR_BUS,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DFLT),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DFLT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   br_taken,
    input  logic [ADDR_W-1:0]      br_target,
    input  logic                   jmp,
    input  logic [ADDR_W-1:0]      jmp_target,
    input  logic                   jr,
    input  logic [ADDR_W-1:0]      jr_target,
    input  logic                   exc_req,
    input  logic                   eret,
    input  logic [ADDR_W-1:0]      epc_in,
    input  logic                   halt,
    input  logic                   mdu_start,
    input  logic                   mdu_done,
    output logic                   pc_ena,
    output logic [ADDR_W-1:0]      pc_next,
    output logic                   exc_taken,
    output logic [ADDR_W-1:0]      epc_out,
    output logic                   stalled,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   misalign
);

    logic [STATE_W-1:0]     state_q, state_d;
    logic                   exc_pend_q, exc_pend_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [ADDR_W-1:0]      pc_plus4_c;
    logic [ADDR_W-1:0]      sel_pc_c;
    logic                   exc_sel_c;
    logic                   misalign_c;

    // RUN-state next-PC selection
    pc_next_mux #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_mux (
        .pc         (pc),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc_in     (epc_in),
        .jr         (jr),
        .jr_target  (jr_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc_plus4_c (pc_plus4_c),
        .sel_pc_c   (sel_pc_c),
        .exc_sel_c  (exc_sel_c),
        .misalign_c (misalign_c)
    );

    // Next state and zero-latency PC control outputs
    always_comb begin
        state_d     = state_q;
        exc_pend_d  = exc_pend_q;
        stall_cnt_d = stall_cnt_q;
        pc_ena      = DISABLE;
        pc_next     = pc;
        exc_taken   = DISABLE;
        epc_out     = '0;
        misalign    = DISABLE;

        if (rst == RST_ENABLE) begin
            pc_next     = RESET_ADDR;
            state_d     = ST_RUN;
            exc_pend_d  = 1'b0;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // halt beats mdu_start, which beats any redirect
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (mdu_start) begin
                        state_d = ST_WAIT_MDU;
                    end else begin
                        pc_ena    = ENABLE;
                        pc_next   = sel_pc_c;
                        exc_taken = exc_sel_c;
                        misalign  = misalign_c;
                        if (exc_sel_c) begin
                            epc_out = pc;
                        end
                    end
                end
                ST_WAIT_MDU: begin
                    stall_cnt_d = sat_inc(stall_cnt_q);
                    if (halt) begin
                        state_d    = ST_HALT;
                        exc_pend_d = 1'b0;
                    end else if (mdu_done) begin
                        // Deferred trap returns to the instruction after the mult/div
                        state_d    = ST_RUN;
                        exc_pend_d = 1'b0;
                        pc_ena     = ENABLE;
                        if (exc_pend_q || exc_req) begin
                            pc_next   = EXC_VECTOR;
                            exc_taken = ENABLE;
                            epc_out   = pc_plus4_c;
                        end else begin
                            pc_next = pc_plus4_c;
                        end
                    end else if (exc_req) begin
                        exc_pend_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, pending trap and stall counter
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_RUN;
            exc_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            exc_pend_q  <= exc_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stalled   = (state_q == ST_WAIT_MDU);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random
// stimulus, expectations from a behavioural model, compared by a monitor.
module tb_pc_sequencer;

    localparam logic [31:0] RST_A = 32'h0040_0000;
    localparam logic [31:0] EXC_A = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, br_target, jmp_target, jr_target, epc_in;
    logic        br_taken, jmp, jr, exc_req, eret, halt, mdu_start, mdu_done;
    logic        pc_ena, exc_taken, stalled, misalign;
    logic [31:0] pc_next, epc_out, stall_cnt;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .jr(jr), .jr_target(jr_target),
        .exc_req(exc_req), .eret(eret), .epc_in(epc_in),
        .halt(halt), .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_ena(pc_ena), .pc_next(pc_next), .exc_taken(exc_taken),
        .epc_out(epc_out), .stalled(stalled), .stall_cnt(stall_cnt),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [31:0] nxt;
        logic        exc;
        logic [31:0] epc;
        logic        mis;
        logic        stl;
        logic [31:0] cnt;
        logic        chk_nxt;
        logic        chk_epc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: mode flags, pending trap, stall count
    logic        m_wait = 1'b0;
    logic        m_halt = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_cnt  = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model(output exp_t e);
        logic [31:0] tgt;
        logic        redir;
        e.ena = 1'b0; e.nxt = pc; e.exc = 1'b0; e.epc = 32'd0; e.mis = 1'b0;
        e.stl = m_wait; e.cnt = m_cnt; e.chk_nxt = 1'b0; e.chk_epc = 1'b0;
        if (rst) begin
            e.nxt = RST_A; e.chk_nxt = 1'b1; e.chk_epc = 1'b1;
            m_wait = 1'b0; m_halt = 1'b0; m_pend = 1'b0; m_cnt = 32'd0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (m_wait) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (halt) begin
                m_halt = 1'b1; m_wait = 1'b0; m_pend = 1'b0;
            end else if (mdu_done) begin
                e.ena = 1'b1; e.chk_nxt = 1'b1;
                if (m_pend || exc_req) begin
                    e.nxt = EXC_A; e.exc = 1'b1; e.epc = pc + 32'd4; e.chk_epc = 1'b1;
                end else begin
                    e.nxt = pc + 32'd4;
                end
                m_wait = 1'b0; m_pend = 1'b0;
            end else if (exc_req) begin
                m_pend = 1'b1;
            end
        end else begin
            if (halt) begin
                m_halt = 1'b1;
            end else if (mdu_start) begin
                m_wait = 1'b1;
            end else begin
                e.ena = 1'b1; e.chk_nxt = 1'b1;
                redir = 1'b1;
                if (eret)          tgt = epc_in;
                else if (jr)       tgt = jr_target;
                else if (jmp)      tgt = jmp_target;
                else if (br_taken) tgt = br_target;
                else begin         tgt = pc + 32'd4; redir = 1'b0; end
                if (exc_req) begin
                    e.nxt = EXC_A; e.exc = 1'b1; e.epc = pc; e.chk_epc = 1'b1;
                end else begin
                    e.nxt = tgt;
`ifdef PC_SEQ_ALIGN_CHK_EN
                    if (redir && (tgt % 4 != 0)) begin
                        e.nxt = EXC_A; e.exc = 1'b1; e.epc = pc; e.chk_epc = 1'b1; e.mis = 1'b1;
                    end
`endif
                end
            end
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0; exc_req = 1'b0;
        eret = 1'b0; halt = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
        br_target = 32'h0040_1000; jmp_target = 32'h0040_2000;
        jr_target = 32'h0040_3000; epc_in = 32'h0040_4000;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // Push this cycle's expectation, then advance one clock
    task automatic cyc();
        exp_t e;
        model(e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                chk("pc_ena", 32'(pc_ena), 32'(me.ena));
                chk("exc_taken", 32'(exc_taken), 32'(me.exc));
                chk("misalign", 32'(misalign), 32'(me.mis));
                chk("stalled", 32'(stalled), 32'(me.stl));
                chk("stall_cnt", stall_cnt, me.cnt);
                if (me.chk_nxt) chk("pc_next", pc_next, me.nxt);
                if (me.chk_epc) chk("epc_out", epc_out, me.epc);
            end
        end
    end

    initial begin
        idle_inputs();
        pc  = RST_A;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        rst = 1'b1; #1;
        chk("rst_ena", 32'(pc_ena), 32'd0);
        chk("rst_next", pc_next, 32'h0040_0000);
        chk("rst_cnt", stall_cnt, 32'd0);
        cyc();
        rst = 1'b1; cyc();

        // First fetch after release
        idle_inputs(); pc = 32'h0040_0000; #1;
        chk("boot_next", pc_next, 32'h0040_0004);
        chk("boot_ena", 32'(pc_ena), 32'd1);
        cyc();

        // Exception beats jr and branch
        idle_inputs(); pc = 32'h0040_0010;
        exc_req = 1'b1; jr = 1'b1; jr_target = 32'h0040_0100;
        br_taken = 1'b1; br_target = 32'h0040_0020; #1;
        chk("prio_next", pc_next, 32'h0040_0004);
        chk("prio_exc", 32'(exc_taken), 32'd1);
        chk("prio_epc", epc_out, 32'h0040_0010);
        cyc();

        // MDU stall of five cycles
        idle_inputs(); pc = 32'h0040_0040; mdu_start = 1'b1; br_taken = 1'b1; cyc();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1; chk("mdu_hold", 32'(pc_ena), 32'd0);
            cyc();
        end
        mdu_done = 1'b1; #1;
        chk("mdu_done_next", pc_next, 32'h0040_0044);
        chk("mdu_done_ena", 32'(pc_ena), 32'd1);
        cyc();
        idle_inputs(); pc = 32'h0040_0044; #1;
        chk("mdu_cnt", stall_cnt, 32'd5);
        cyc();

        // Trap raised during the stall is applied on completion
        idle_inputs(); pc = 32'h0040_0080; mdu_start = 1'b1; mdu_done = 1'b1; cyc();
        idle_inputs(); exc_req = 1'b1; cyc();
        idle_inputs(); cyc();
        mdu_done = 1'b1; #1;
        chk("pend_next", pc_next, 32'h0040_0004);
        chk("pend_epc", epc_out, 32'h0040_0084);
        cyc();
        idle_inputs(); pc = 32'h0040_0004; #1;
        chk("pend_clr_exc", 32'(exc_taken), 32'd0);
        chk("pend_clr_next", pc_next, 32'h0040_0008);
        cyc();

        // Wrap, then halt until reset
        idle_inputs(); pc = 32'hFFFF_FFFC; #1;
        chk("wrap_next", pc_next, 32'h0000_0000);
        cyc();
        halt = 1'b1; cyc();
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            jr = 1'($urandom); exc_req = 1'($urandom); mdu_done = 1'($urandom);
            pc = $urandom & 32'hFFFF_FFFC; #1;
            chk("halt_hold", 32'(pc_ena), 32'd0);
            cyc();
        end
        idle_inputs(); rst = 1'b1; cyc();
        idle_inputs(); pc = 32'h0040_0000; #1;
        chk("halt_rst_ena", 32'(pc_ena), 32'd1);
        cyc();

        // Misaligned jr target
        idle_inputs(); pc = 32'h0040_0200; jr = 1'b1; jr_target = 32'h0040_0102; #1;
`ifdef PC_SEQ_ALIGN_CHK_EN
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_next", pc_next, 32'h0040_0004);
`else
        chk("mis_flag", 32'(misalign), 32'd0);
        chk("mis_next", pc_next, 32'h0040_0102);
`endif
        cyc();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst       = ($urandom_range(0, 99) < 2);
            halt      = ($urandom_range(0, 199) < 1);
            exc_req   = ($urandom_range(0, 9) == 0);
            eret      = ($urandom_range(0, 9) == 0);
            jr        = ($urandom_range(0, 6) == 0);
            jmp       = ($urandom_range(0, 6) == 0);
            br_taken  = ($urandom_range(0, 4) == 0);
            mdu_start = ($urandom_range(0, 9) == 0);
            mdu_done  = ($urandom_range(0, 3) == 0);
            br_target = rand_tgt(); jmp_target = rand_tgt();
            jr_target = rand_tgt(); epc_in = rand_tgt();
            pc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc();
        end

        idle_inputs();
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
